axi_xb_ingress_fifo: RTL and testbench
======================================

# axi_xb_ingress_fifo

Per-port ingress buffer for the AXI crossbar. Each crossbar input has one. The block buffers one AXI4-Stream port in a small first-word-fall-through FIFO and tracks how many complete packets it holds. It drives the crossbar's `i_tdata`/`i_tvalid`/`i_tlast`/`i_tready` and `pkt_present` inputs for that port. It replaces the separate short-FIFO and monitor pair, so the whole-packet status is exact by construction.

## Interface
- `WIDTH`, 64: tdata width in bits; stored word is WIDTH+1 bits (tlast included).
- `SIZE`, 5: log2 of FIFO depth (depth = 2^SIZE lines).
- `COUNT_BITS`, 8: width of `pkt_count`; must be ≥ SIZE+1 (elaboration-time check, `$error` otherwise).

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush, same effect as reset on the next edge.
- `i_tdata`  in  WIDTH  upstream data.
- `i_tlast`  in  1  upstream end-of-packet.
- `i_tvalid`  in  1  upstream valid.
- `i_tready`  out  1  not full.
- `o_tdata`  out  WIDTH  head-of-FIFO data (to crossbar).
- `o_tlast`  out  1  head-of-FIFO last.
- `o_tvalid`  out  1  head valid (subject to gating, see Configuration).
- `o_tready`  in  1  crossbar ready.
- `pkt_present`  out  1  `pkt_count != 0`.
- `pkt_count`  out  COUNT_BITS  complete packets held.
- `space`  out  SIZE+1  free lines.
- `occupied`  out  SIZE+1  used lines.

## Operation
- Write on `i_tvalid & i_tready`: store `{i_tlast,i_tdata}` at `wr_ptr`; wr_ptr += 1 modulo 2^SIZE.
- Read on `o_tvalid & o_tready`: rd_ptr += 1 modulo 2^SIZE.
- `occupied` +1 on write only, −1 on read only, unchanged on both or neither. `space = 2^SIZE − occupied`.
- `i_tready = (occupied != 2^SIZE)`. A write while full is impossible by handshake. A simultaneous read and write while full is not accepted, because ready is already low.
- `pkt_count`: +1 on an accepted write with `i_tlast`; −1 on an accepted read with `o_tlast`; unchanged when both happen in the same cycle. It never exceeds 2^SIZE, because every packet occupies at least one line.
- Empty: `o_tvalid=0`; `o_tdata`/`o_tlast` hold stale memory contents and are don't-care.
- Reset (async) or clear (sync) forces:
  - pointers, `occupied` and `pkt_count` to 0;
  - `space` to 2^SIZE;
  - `o_tvalid` and `pkt_present` to 0;
  - `i_tready` to 0 while `reset` is high, and 1 from the first edge after deassertion.
- Reset or clear mid-packet discards all partial and complete packets. There is no recovery beat.

## Timing
- Write-to-output latency is 1 cycle. A word accepted at edge N is on `o_tdata` with `o_tvalid=1` after edge N (cut-through build) when the FIFO was empty.
- `o_tdata` is a combinational read of `mem[rd_ptr]` (distributed RAM), so it is FWFT.
- `pkt_present` rises on the edge that accepts the tlast beat. It falls on the edge that consumes the last tlast beat held.
- `i_tready` depends only on registered state; there is no combinational path from `o_tready`.
- Full throughput is sustained: one write and one read per cycle at any occupancy other than full with no read.

## Configuration
- Macro `AXI_XB_INGRESS_GATE_EN`.
- **Defined (store-and-forward):**
  - `o_tvalid = !empty & (pkt_count != 0 | mid_pkt | full)`, where `mid_pkt` is set when a non-last beat is read and cleared when a last beat is read.
  - The `full` term releases packets longer than the FIFO depth, which would otherwise deadlock. Once released, such a packet streams in cut-through.
- **Undefined (cut-through):** `o_tvalid = !empty`. `mid_pkt` logic is not built.

## Structure
- Shared package `axi_xb_pkg`:
  - `XB_STREAM_WIDTH` (64);
  - the default `SIZE`;
  - a `function automatic clog2`;
  - the typedef for the stored word, `{last, data}`.
- One sub-module, `axi_xb_pkt_counter`. It takes the write-side and read-side last strobes and holds the up/down `pkt_count` plus the `mid_pkt` flag. The top level instantiates it once.

## Test plan
- **Reset:** hold `reset` 3 cycles, then release with no traffic → `occupied=0`, `space=32`, `pkt_count=0`, `o_tvalid=0`; `i_tready=0` during reset, 1 after.
- **Single 4-beat packet, `o_tready=0`:** write beats 0x1..0x4 with tlast on 0x4.
  - Cut-through: `o_tvalid=1` one cycle after beat 0x1.
  - Gated: `o_tvalid=1` only after beat 0x4.
  - Both: `pkt_count=1`, `occupied=4`.
- **Fill:** write 32 non-last beats with `o_tready=0` → `i_tready=0` with `occupied=32`. In gated mode `o_tvalid=1` via the full override. Draining 1 beat brings `i_tready` back to 1 the next cycle.
- **Simultaneous tlast in and tlast out:** start with `pkt_count=2`, write a last beat and read a last beat on the same edge → `pkt_count` stays 2 and `occupied` is unchanged.
- **Clear mid-packet:** after 3 beats of an unfinished packet, pulse `clear` 1 cycle → `occupied=0`, `pkt_count=0`, `o_tvalid=0`. The next packet is 0xA (tlast) and is read back as exactly 0xA.
- **Wrap-around:** stream 100 packets of random 1–7 beats through with random `o_tready` → output matches input in order, `pkt_count` ends at 0, and no beat is lost or duplicated.

Source files
------------

// File: rtl/axi_xb_pkg.sv
// Shared definitions for the AXI crossbar ingress path.
//   XB_STREAM_WIDTH : default tdata width of a crossbar stream
//   XB_FIFO_SIZE    : default log2 depth of an ingress FIFO
//   clog2()         : constant-evaluable ceiling log2
//   xb_word_t       : stored FIFO word, {last, data}
package axi_xb_pkg;

    localparam int XB_STREAM_WIDTH = 64;
    localparam int XB_FIFO_SIZE    = 5;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic                       last;
        logic [XB_STREAM_WIDTH-1:0] data;
    } xb_word_t;

endpackage

// File: rtl/axi_xb_pkt_counter.sv
// Complete-packet counter for the ingress FIFO.
//   clk, reset (async, active high), clear (sync flush)
//   wr_fire_i / wr_last_i : write handshake and its tlast
//   rd_fire_i / rd_last_i : read handshake and the head tlast
//   pkt_count_o           : complete packets currently held
//   mid_pkt_o             : a packet has been partly read out
// Macro AXI_XB_INGRESS_GATE_EN builds the mid_pkt flag; otherwise it is tied low.
module axi_xb_pkt_counter
    import axi_xb_pkg::*;
#(
    parameter int COUNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_fire_i,
    input  logic                  wr_last_i,
    input  logic                  rd_fire_i,
    input  logic                  rd_last_i,
    output logic [COUNT_BITS-1:0] pkt_count_o,
    output logic                  mid_pkt_o
);

    logic                  pkt_in;
    logic                  pkt_out;
    logic [COUNT_BITS-1:0] count_q;
    logic [COUNT_BITS-1:0] count_d;

    assign pkt_in  = wr_fire_i & wr_last_i;
    assign pkt_out = rd_fire_i & rd_last_i;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (pkt_in && !pkt_out) begin
            count_d = count_q + 1'b1;
        end else if (pkt_out && !pkt_in) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pkt_count_o = count_q;

`ifdef AXI_XB_INGRESS_GATE_EN
    logic mid_q;
    logic mid_d;

    always_comb begin
        mid_d = mid_q;
        if (clear) begin
            mid_d = 1'b0;
        end else if (rd_fire_i) begin
            mid_d = !rd_last_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mid_q <= 1'b0;
        end else begin
            mid_q <= mid_d;
        end
    end

    assign mid_pkt_o = mid_q;
`else
    assign mid_pkt_o = 1'b0;
`endif

endmodule

// File: rtl/axi_xb_ingress_fifo.sv
// Per-port ingress buffer for the AXI crossbar: a first-word-fall-through
// FIFO of {tlast, tdata} words with an exact count of complete packets.
//   clk, reset (async, active high), clear (sync flush)
//   i_tdata/i_tlast/i_tvalid/i_tready : upstream AXI4-Stream slave side
//   o_tdata/o_tlast/o_tvalid/o_tready : crossbar-facing master side
//   pkt_present, pkt_count             : complete packets held
//   space, occupied                    : free / used lines
// Macro AXI_XB_INGRESS_GATE_EN selects store-and-forward gating of o_tvalid;
// without it the FIFO is cut-through.
module axi_xb_ingress_fifo
    import axi_xb_pkg::*;
#(
    parameter int WIDTH      = XB_STREAM_WIDTH,
    parameter int SIZE       = XB_FIFO_SIZE,
    parameter int COUNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      i_tdata,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic [WIDTH-1:0]      o_tdata,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    output logic                  pkt_present,
    output logic [COUNT_BITS-1:0] pkt_count,
    output logic [SIZE:0]         space,
    output logic [SIZE:0]         occupied
);

    localparam int            DEPTH_I = 1 << SIZE;
    localparam logic [SIZE:0] DEPTH   = DEPTH_I[SIZE:0];

    // Every packet uses at least one line, so the count can reach DEPTH.
    if (COUNT_BITS < clog2(DEPTH_I) + 1) begin : g_count_bits_check
        $error("axi_xb_ingress_fifo: COUNT_BITS must be at least SIZE+1");
    end

    logic [WIDTH:0]  mem [DEPTH_I];
    logic [WIDTH:0]  head;
    logic [SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [SIZE:0]   occ_q, occ_d;
    logic            rdy_en_q;
    logic            empty, full;
    logic            wr_fire, rd_fire;
    logic            mid_pkt;

    assign empty   = (occ_q == '0);
    assign full    = (occ_q == DEPTH);
    // rdy_en_q keeps ready low while reset is held and for no longer.
    assign i_tready = rdy_en_q & !full;
    assign wr_fire = i_tvalid & i_tready;
    assign rd_fire = o_tvalid & o_tready;

`ifdef AXI_XB_INGRESS_GATE_EN
    // The full term lets a packet longer than the FIFO escape; mid_pkt then
    // keeps it flowing until its last beat leaves.
    assign o_tvalid = !empty & ((pkt_count != '0) | mid_pkt | full);
`else
    logic unused_mid_pkt;
    assign unused_mid_pkt = mid_pkt;
    assign o_tvalid = !empty;
`endif

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= {i_tlast, i_tdata};
        end
    end

    assign head    = mem[rd_ptr_q];
    assign o_tdata = head[WIDTH-1:0];
    assign o_tlast = head[WIDTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rdy_en_q <= 1'b1;
        end
    end

    axi_xb_pkt_counter #(
        .COUNT_BITS (COUNT_BITS)
    ) u_pkt_counter (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .wr_fire_i   (wr_fire),
        .wr_last_i   (i_tlast),
        .rd_fire_i   (rd_fire),
        .rd_last_i   (o_tlast),
        .pkt_count_o (pkt_count),
        .mid_pkt_o   (mid_pkt)
    );

    assign pkt_present = (pkt_count != '0);
    assign occupied    = occ_q;
    assign space       = DEPTH - occ_q;

endmodule

// File: tb/tb_axi_xb_ingress_fifo.sv
module tb_axi_xb_ingress_fifo;
    import axi_xb_pkg::*;

    localparam int W     = 64;
    localparam int SZ    = 5;
    localparam int CB    = 8;
    localparam int DEPTH = 32;
`ifdef AXI_XB_INGRESS_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          clear;
    logic [W-1:0]  i_tdata;
    logic          i_tlast;
    logic          i_tvalid;
    logic          i_tready;
    logic [W-1:0]  o_tdata;
    logic          o_tlast;
    logic          o_tvalid;
    logic          o_tready;
    logic          pkt_present;
    logic [CB-1:0] pkt_count;
    logic [SZ:0]   space;
    logic [SZ:0]   occupied;

    int n_checks = 0;
    int n_fail   = 0;

    axi_xb_ingress_fifo #(.WIDTH(W), .SIZE(SZ), .COUNT_BITS(CB)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .i_tdata     (i_tdata),
        .i_tlast     (i_tlast),
        .i_tvalid    (i_tvalid),
        .i_tready    (i_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .pkt_present (pkt_present),
        .pkt_count   (pkt_count),
        .space       (space),
        .occupied    (occupied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the FIFO contents as a queue of words.
    xb_word_t mq[$];
    bit       m_mid    = 1'b0;
    bit       m_rdy_en = 1'b0;

    function automatic int m_pkts();
        int n;
        n = 0;
        foreach (mq[i]) if (mq[i].last) n++;
        return n;
    endfunction

    function automatic bit m_ready();
        return m_rdy_en && (mq.size() != DEPTH);
    endfunction

    function automatic bit m_valid();
        if (mq.size() == 0) return 1'b0;
        if (!GATED) return 1'b1;
        return (m_pkts() != 0) || m_mid || (mq.size() == DEPTH);
    endfunction

    always @(posedge clk or posedge reset) begin
        bit w, r;
        xb_word_t tmp;
        if (reset) begin
            mq.delete();
            m_mid    = 1'b0;
            m_rdy_en = 1'b0;
        end else if (clear) begin
            mq.delete();
            m_mid    = 1'b0;
            m_rdy_en = 1'b1;
        end else begin
            w = i_tvalid && m_ready();
            r = m_valid() && o_tready;
            if (r) begin
                tmp   = mq.pop_front();
                m_mid = !tmp.last;
            end
            if (w) mq.push_back({i_tlast, i_tdata});
            m_rdy_en = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0;
        i_tdata = '0; o_tready = 1'b0;
        repeat (3) begin
            tick();
            n_checks++;
            if (i_tready !== 1'b0) begin
                n_fail++; $display("FAIL reset_ready_low: got %b expected 0", i_tready);
            end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (i_tready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high: got %b expected 1", i_tready); end
        n_checks++;
        if (occupied !== 6'd0) begin n_fail++; $display("FAIL reset_occupied: got %0d expected 0", occupied); end
        n_checks++;
        if (space !== 6'd32) begin n_fail++; $display("FAIL reset_space: got %0d expected 32", space); end
        n_checks++;
        if (pkt_count !== 8'd0 || pkt_present !== 1'b0) begin
            n_fail++; $display("FAIL reset_pkt: got %0d/%b expected 0/0", pkt_count, pkt_present);
        end
        n_checks++;
        if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", o_tvalid); end
    endtask

    task automatic test_single_pkt();
        logic exp_v;
        o_tready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            i_tvalid = 1'b1; i_tdata = W'(k); i_tlast = (k == 4);
            tick();
            exp_v = GATED ? (k == 4) : 1'b1;
            n_checks++;
            if (o_tvalid !== exp_v) begin
                n_fail++; $display("FAIL single_tvalid beat %0d: got %b expected %b", k, o_tvalid, exp_v);
            end
        end
        i_tvalid = 1'b0; i_tlast = 1'b0;
        n_checks++;
        if (pkt_count !== 8'd1 || pkt_present !== 1'b1) begin
            n_fail++; $display("FAIL single_pkt_count: got %0d/%b expected 1/1", pkt_count, pkt_present);
        end
        n_checks++;
        if (occupied !== 6'd4) begin n_fail++; $display("FAIL single_occupied: got %0d expected 4", occupied); end
        o_tready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (o_tvalid !== 1'b1 || o_tdata !== W'(k) || o_tlast !== (k == 4)) begin
                n_fail++;
                $display("FAIL single_drain beat %0d: got v=%b d=%0h l=%b expected v=1 d=%0h l=%b",
                         k, o_tvalid, o_tdata, o_tlast, k, (k == 4));
            end
            tick();
        end
        o_tready = 1'b0;
        n_checks++;
        if (occupied !== 6'd0 || pkt_present !== 1'b0) begin
            n_fail++; $display("FAIL single_empty: got occ=%0d pp=%b expected 0/0", occupied, pkt_present);
        end
    endtask

    task automatic test_fill();
        o_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            i_tvalid = 1'b1; i_tlast = 1'b0; i_tdata = W'(100 + i);
            tick();
        end
        i_tvalid = 1'b0;
        n_checks++;
        if (occupied !== 6'd32 || space !== 6'd0) begin
            n_fail++; $display("FAIL fill_occupied: got occ=%0d space=%0d expected 32/0", occupied, space);
        end
        n_checks++;
        if (i_tready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", i_tready); end
        n_checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== W'(100)) begin
            n_fail++; $display("FAIL fill_tvalid: got v=%b d=%0h expected v=1 d=64", o_tvalid, o_tdata);
        end
        // write offered together with the read while full must not land
        i_tvalid = 1'b1; i_tdata = W'(999); o_tready = 1'b1;
        tick();
        i_tvalid = 1'b0; o_tready = 1'b0;
        n_checks++;
        if (occupied !== 6'd31 || i_tready !== 1'b1) begin
            n_fail++; $display("FAIL fill_drain1: got occ=%0d rdy=%b expected 31/1", occupied, i_tready);
        end
        n_checks++;
        if (o_tdata !== W'(101)) begin n_fail++; $display("FAIL fill_head: got %0h expected 65", o_tdata); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++;
        if (occupied !== 6'd0 || o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
            n_fail++; $display("FAIL fill_clear: got occ=%0d v=%b rdy=%b expected 0/0/1", occupied, o_tvalid, i_tready);
        end
    endtask

    task automatic test_simul_last();
        o_tready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_tvalid = 1'b1; i_tlast = 1'b1; i_tdata = W'(8'h51 + k);
            tick();
        end
        n_checks++;
        if (pkt_count !== 8'd2) begin n_fail++; $display("FAIL simul_pre: got %0d expected 2", pkt_count); end
        i_tdata = W'(8'h53); o_tready = 1'b1;
        tick();
        i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b0;
        n_checks++;
        if (pkt_count !== 8'd2 || occupied !== 6'd2) begin
            n_fail++; $display("FAIL simul_last: got cnt=%0d occ=%0d expected 2/2", pkt_count, occupied);
        end
        o_tready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_tvalid !== 1'b1 || o_tdata !== W'(8'h52 + k) || o_tlast !== 1'b1) begin
                n_fail++; $display("FAIL simul_drain %0d: got v=%b d=%0h expected v=1 d=%0h", k, o_tvalid, o_tdata, 8'h52 + k);
            end
            tick();
        end
        o_tready = 1'b0;
        n_checks++;
        if (pkt_count !== 8'd0 || occupied !== 6'd0) begin
            n_fail++; $display("FAIL simul_empty: got cnt=%0d occ=%0d expected 0/0", pkt_count, occupied);
        end
    endtask

    task automatic test_clear_mid();
        o_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_tvalid = 1'b1; i_tlast = 1'b0; i_tdata = W'(8'h61 + k);
            tick();
        end
        i_tvalid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++;
        if (occupied !== 6'd0 || pkt_count !== 8'd0 || o_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL clear_mid: got occ=%0d cnt=%0d v=%b expected 0/0/0", occupied, pkt_count, o_tvalid);
        end
        i_tvalid = 1'b1; i_tlast = 1'b1; i_tdata = W'(8'hA);
        tick();
        i_tvalid = 1'b0; i_tlast = 1'b0;
        n_checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== W'(8'hA) || o_tlast !== 1'b1 || occupied !== 6'd1) begin
            n_fail++; $display("FAIL clear_next: got v=%b d=%0h l=%b occ=%0d expected 1/a/1/1", o_tvalid, o_tdata, o_tlast, occupied);
        end
        o_tready = 1'b1;
        tick();
        o_tready = 1'b0;
        n_checks++;
        if (occupied !== 6'd0 || o_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL clear_after: got occ=%0d v=%b expected 0/0", occupied, o_tvalid);
        end
    endtask

    task automatic test_wrap();
        xb_word_t stim[$];
        xb_word_t got[$];
        int idx;
        int cyc;
        int len;
        idx = 0; cyc = 0;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 7);
            for (int b = 0; b < len; b++) stim.push_back({(b == len - 1), {$urandom, $urandom}});
        end
        while (got.size() < stim.size() && cyc < 20000) begin
            n_checks++;
            if (o_tvalid !== m_valid() || i_tready !== m_ready()) begin
                n_fail++; $display("FAIL wrap_hs cyc %0d: got v=%b r=%b expected v=%b r=%b", cyc, o_tvalid, i_tready, m_valid(), m_ready());
            end
            n_checks++;
            if (occupied !== 6'(mq.size()) || pkt_count !== 8'(m_pkts())) begin
                n_fail++; $display("FAIL wrap_counts cyc %0d: got occ=%0d cnt=%0d expected %0d/%0d", cyc, occupied, pkt_count, mq.size(), m_pkts());
            end
            if (m_valid()) begin
                n_checks++;
                if ({o_tlast, o_tdata} !== mq[0]) begin
                    n_fail++; $display("FAIL wrap_head cyc %0d: got %0h expected %0h", cyc, {o_tlast, o_tdata}, mq[0]);
                end
            end
            if (idx < stim.size() && $urandom_range(0, 3) != 0) begin
                i_tvalid = 1'b1; i_tdata = stim[idx].data; i_tlast = stim[idx].last;
            end else begin
                i_tvalid = 1'b0; i_tlast = 1'b0;
            end
            o_tready = ($urandom_range(0, 2) != 0);
            if (i_tvalid && m_ready()) idx++;
            if (o_tvalid === 1'b1 && o_tready) got.push_back({o_tlast, o_tdata});
            tick();
            cyc++;
        end
        i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b0;
        n_checks++;
        if (got.size() != stim.size()) begin
            n_fail++; $display("FAIL wrap_total: got %0d beats expected %0d", got.size(), stim.size());
        end
        for (int i = 0; i < got.size() && i < stim.size(); i++) begin
            n_checks++;
            if (got[i] !== stim[i]) begin
                n_fail++; $display("FAIL wrap_order beat %0d: got %0h expected %0h", i, got[i], stim[i]);
            end
        end
        n_checks++;
        if (pkt_count !== 8'd0 || occupied !== 6'd0) begin
            n_fail++; $display("FAIL wrap_end: got cnt=%0d occ=%0d expected 0/0", pkt_count, occupied);
        end
    endtask

    initial begin
        test_reset();
        test_single_pkt();
        test_fill();
        test_simul_last();
        test_clear_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
